// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared FSM state type and default operand width
package serial_add_ctrl_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/serial_add_ctrl_add1b.sv
// add1b: 1-bit full adder; a, b, ci in -> r sum bit, co carry out
module add1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic r,
  output logic co
);
  assign r  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial {co,r} = a + b + ci, LSB first, one shared full adder
// clk/rst_n clock and async active-low reset; start/a/b/ci request and operands;
// busy while bits are processed, done one-cycle result pulse, r/co/ovf held results
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             co,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_nx;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic c, s, c_nx, last, accept;
  add1b u_fa (.a(sa[0]), .b(sb[0]), .ci(c), .r(s), .co(c_nx));
  assign last   = cnt == CW'(WIDTH - 1);
  assign accept = state == IDLE && start;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    busy = state == RUN;
    done = state == DONE;
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  // r fills from the MSB side so after WIDTH shifts bit 0 sits at r[0];
  // c still holds the carry into the MSB on the last bit, giving ovf
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sa <= '0;
      sb <= '0;
      c <= 1'b0;
      cnt <= '0;
      r <= '0;
      co <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      sa <= a;
      sb <= b;
      c <= ci;
      cnt <= '0;
    end else if (state == RUN) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      c <= c_nx;
      cnt <= cnt + CW'(1);
      r <= {s, r[WIDTH-1:1]};
      if (last) begin
        co <= c_nx;
        ovf <= c ^ c_nx;
      end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized and directed self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, ci = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, co, ovf;
  logic [W-1:0] r;
  int vectors = 0, miscompares = 0;
  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .r(r), .co(co), .ovf(ovf)
  );
  always #5 clk = ~clk;
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] sum;
    logic v;
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]);
    return {v, sum};
  endfunction
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc, input bit scramble,
                        output int done_at, output int ndone, output int busy_bad, output logic [W+1:0] res);
    @(negedge clk);
    a = xa;
    b = xb;
    ci = xc;
    start = 1'b1;
    done_at = -1;
    ndone = 0;
    busy_bad = 0;
    res = '0;
    for (int i = 1; i <= W + 3; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (done_at < 0) begin
          done_at = i;
          res = {ovf, co, r};
        end
      end
      if (busy !== (i <= W)) busy_bad++;
      start = 1'b0;
      if (scramble && i <= W) begin
        start = 1'($urandom_range(0, 1));
        a = W'($urandom);
        b = W'($urandom);
        ci = 1'($urandom);
      end
    end
  endtask
  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({busy, done, co, ovf, r} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b co=%b ovf=%b r=%h, want all 0", busy, done, co, ovf, r);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask
  task automatic test_directed();
    logic [W-1:0] ta [5] = '{8'h01, 8'hFF, 8'h7F, 8'hFF, 8'h80};
    logic [W-1:0] tb [5] = '{8'h00, 8'h01, 8'h01, 8'h00, 8'h80};
    logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W+1:0] te [5] = '{10'b0_0_00000001, 10'b0_1_00000000, 10'b1_0_10000000,
                             10'b0_1_00000000, 10'b1_1_00000000};
    int done_at, ndone, busy_bad;
    logic [W+1:0] res;
    for (int k = 0; k < 5; k++) begin
      run_op(ta[k], tb[k], tc[k], 1'b0, done_at, ndone, busy_bad, res);
      vectors++;
      if (done_at !== W + 1 || ndone !== 1 || busy_bad !== 0) begin
        miscompares++;
        $display("FAIL directed_timing[%0d]: done_at=%0d ndone=%0d busy_bad=%0d, want %0d 1 0", k, done_at, ndone, busy_bad, W + 1);
      end
      vectors++;
      if (res !== te[k]) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: {ovf,co,r}=%b, want %b", k, res, te[k]);
      end
    end
  endtask
  task automatic test_random();
    int done_at, ndone, busy_bad;
    logic [W+1:0] res, exp;
    logic [W-1:0] xa, xb;
    logic xc;
    for (int k = 0; k < 24; k++) begin
      xa = W'($urandom);
      xb = W'($urandom);
      xc = 1'($urandom);
      exp = model(xa, xb, xc);
      run_op(xa, xb, xc, 1'b0, done_at, ndone, busy_bad, res);
      vectors++;
      if (res !== exp || done_at !== W + 1 || ndone !== 1 || busy_bad !== 0) begin
        miscompares++;
        $display("FAIL random[%0d] %h+%h+%b: {ovf,co,r}=%b done_at=%0d ndone=%0d busy_bad=%0d, want %b at %0d",
                 k, xa, xb, xc, res, done_at, ndone, busy_bad, exp, W + 1);
      end
    end
  endtask
  task automatic test_ignore_start();
    int done_at, ndone, busy_bad;
    logic [W+1:0] res, exp;
    logic [W-1:0] xa, xb;
    logic xc;
    for (int k = 0; k < 6; k++) begin
      xa = W'($urandom);
      xb = W'($urandom);
      xc = 1'($urandom);
      exp = model(xa, xb, xc);
      run_op(xa, xb, xc, 1'b1, done_at, ndone, busy_bad, res);
      vectors++;
      if (res !== exp || ndone !== 1 || done_at !== W + 1) begin
        miscompares++;
        $display("FAIL ignore_start[%0d]: {ovf,co,r}=%b ndone=%0d done_at=%0d, want %b 1 %0d", k, res, ndone, done_at, exp, W + 1);
      end
    end
  endtask
  task automatic test_reset_mid_run();
    int done_at, ndone, busy_bad, seen;
    logic [W+1:0] res;
    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    ci = 1'b1;
    start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, co, ovf, r} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset_clear: busy=%b done=%b co=%b ovf=%b r=%h, want all 0", busy, done, co, ovf, r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL midrun_reset_abort: busy/done seen %0d cycles, want 0", seen);
    end
    run_op(8'h12, 8'h34, 1'b0, 1'b0, done_at, ndone, busy_bad, res);
    vectors++;
    if (res !== 10'b0_0_01000110 || done_at !== W + 1 || ndone !== 1) begin
      miscompares++;
      $display("FAIL after_reset_op: {ovf,co,r}=%b done_at=%0d ndone=%0d, want 0001000110 %0d 1", res, done_at, ndone, W + 1);
    end
  endtask
  task automatic test_back_to_back();
    int d [$];
    int busy_bad;
    logic [W+1:0] exp;
    bit exp_busy;
    exp = model(8'h3C, 8'h0F, 1'b1);
    @(negedge clk);
    a = 8'h3C;
    b = 8'h0F;
    ci = 1'b1;
    start = 1'b1;
    busy_bad = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      exp_busy = ((i - 1) % (W + 2)) < W && i <= 3 * (W + 2) - 2;
      if (busy !== exp_busy) busy_bad++;
      if (done) begin
        d.push_back(i);
        vectors++;
        if ({ovf, co, r} !== exp) begin
          miscompares++;
          $display("FAIL b2b_result at %0d: {ovf,co,r}=%b, want %b", i, {ovf, co, r}, exp);
        end
      end
      if (i == 3 * (W + 2) - 1) start = 1'b0;
    end
    vectors++;
    if (d.size() !== 3) begin
      miscompares++;
      $display("FAIL b2b_count: %0d done pulses, want 3", d.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (d[k] !== (W + 1) + k * (W + 2)) begin
          miscompares++;
          $display("FAIL b2b_spacing[%0d]: done at %0d, want %0d", k, d[k], (W + 1) + k * (W + 2));
        end
      end
    end
    vectors++;
    if (busy_bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_busy: %0d busy mismatches, want 0", busy_bad);
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
